// File: rtl/sync_fifo_thr_if.sv
// Producer/consumer bundle for sync_fifo_thr: request/data inputs and occupancy/status outputs.
interface sync_fifo_thr_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int ADDR_W     = 3
);
    logic                  i_push;
    logic                  i_pop;
    logic                  i_flush;
    logic [FIFO_WIDTH-1:0] in_fifo;
    logic [FIFO_WIDTH-1:0] out_fifo;
    logic                  out_valid;
    logic [ADDR_W:0]       level;
    logic                  is_fifo_empty;
    logic                  is_fifo_full;
    logic                  is_almost_full;
    logic                  is_almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output i_push, i_pop, i_flush, in_fifo,
        input  out_fifo, out_valid, level, is_fifo_empty, is_fifo_full,
               is_almost_full, is_almost_empty, overflow, underflow
    );

    modport slave (
        input  i_push, i_pop, i_flush, in_fifo,
        output out_fifo, out_valid, level, is_fifo_empty, is_fifo_full,
               is_almost_full, is_almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with wrap-bit pointers, occupancy thresholds, sticky error flags
// and a selectable first-word-fall-through read port.
module sync_fifo_thr #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH),
    parameter int AFULL_TH   = FIFO_DEPTH - 2,
    parameter int AEMPTY_TH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_thr_if.slave  fifo
);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] PT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [FIFO_WIDTH-1:0] ram_q [FIFO_DEPTH];

    logic [ADDR_W:0]       wr_pt_q, wr_pt_d;
    logic [ADDR_W:0]       rd_pt_q, rd_pt_d;
    logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic [ADDR_W:0]       level_w;
    logic                  empty_w, full_w;
    logic                  pop_ok, push_ok;

    // Status comes only from the registered pointers; the MSB separates full from empty.
    assign level_w = wr_pt_q - rd_pt_q;
    assign empty_w = (level_w == '0);
    assign full_w  = (level_w == DEPTH_L);

    // A pop frees the slot the simultaneous push needs, so full+push+pop is lossless.
    assign pop_ok  = fifo.i_pop && !empty_w;
    assign push_ok = fifo.i_push && (!full_w || pop_ok);

    always_comb begin
        wr_pt_d     = wr_pt_q;
        rd_pt_d     = rd_pt_q;
        rd_data_d   = rd_data_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        if (fifo.i_flush) begin
            wr_pt_d = '0;
            rd_pt_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                wr_pt_d = wr_pt_q + PT_ONE;
            end
            if (pop_ok) begin
                rd_pt_d     = rd_pt_q + PT_ONE;
                rd_data_d   = ram_q[rd_pt_q[ADDR_W-1:0]];
                out_valid_d = 1'b1;
            end
            if (fifo.i_push && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (fifo.i_pop && !pop_ok) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_pt_q     <= '0;
            rd_pt_q     <= '0;
            rd_data_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wr_pt_q     <= wr_pt_d;
            rd_pt_q     <= rd_pt_d;
            rd_data_q   <= rd_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !fifo.i_flush && push_ok) begin
            ram_q[wr_pt_q[ADDR_W-1:0]] <= fifo.in_fifo;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign fifo.out_fifo  = ram_q[rd_pt_q[ADDR_W-1:0]];
            assign fifo.out_valid = !empty_w;
        end else begin : g_std
            assign fifo.out_fifo  = rd_data_q;
            assign fifo.out_valid = out_valid_q;
        end
    endgenerate

    assign fifo.level           = level_w;
    assign fifo.is_fifo_empty   = empty_w;
    assign fifo.is_fifo_full    = full_w;
    assign fifo.is_almost_full  = (level_w >= AFULL_L);
    assign fifo.is_almost_empty = (level_w <= AEMPTY_L);
    assign fifo.overflow        = ovf_q;
    assign fifo.underflow       = udf_q;
endmodule

// File: tb/tb_sync_fifo_thr.sv
// Bench for sync_fifo_thr: a standard-mode and an FWFT instance share one stimulus stream
// and are checked every cycle against a queue model, plus literal checkpoints.
module tb_sync_fifo_thr;
    localparam int W = 16;
    localparam int D = 8;
    localparam int A = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [W-1:0] din = '0;

    int vectors = 0;
    int miscompares = 0;
    bit en_cmp = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_thr_if #(.FIFO_WIDTH(W), .ADDR_W(A)) bus_s ();
    sync_fifo_thr_if #(.FIFO_WIDTH(W), .ADDR_W(A)) bus_f ();

    assign bus_s.i_push  = push;
    assign bus_s.i_pop   = pop;
    assign bus_s.i_flush = flush;
    assign bus_s.in_fifo = din;
    assign bus_f.i_push  = push;
    assign bus_f.i_pop   = pop;
    assign bus_f.i_flush = flush;
    assign bus_f.in_fifo = din;

    sync_fifo_thr #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1'b0)) dut_std (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (bus_s)
    );

    sync_fifo_thr #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1'b1)) dut_fwft (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (bus_f)
    );

    // Behavioural model: contents as a queue, outputs from the stated rules.
    logic [W-1:0] q[$];
    logic [W-1:0] m_out = '0;
    bit m_vld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    bit can_pop, can_push;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_out = '0;
            m_vld = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_vld = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            can_pop  = pop && (q.size() > 0);
            can_push = push && ((q.size() < D) || can_pop);
            m_vld = can_pop;
            if (can_pop) m_out = q.pop_front();
            if (push && !can_push) m_ovf = 1'b1;
            if (pop && !can_pop) m_udf = 1'b1;
            if (can_push) q.push_back(din);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_cmp) begin
            check("level",     int'(bus_s.level),           q.size());
            check("empty",     int'(bus_s.is_fifo_empty),   int'(q.size() == 0));
            check("full",      int'(bus_s.is_fifo_full),    int'(q.size() == D));
            check("afull",     int'(bus_s.is_almost_full),  int'(q.size() >= D - 2));
            check("aempty",    int'(bus_s.is_almost_empty), int'(q.size() <= 1));
            check("overflow",  int'(bus_s.overflow),        int'(m_ovf));
            check("underflow", int'(bus_s.underflow),       int'(m_udf));
            check("std_valid", int'(bus_s.out_valid),       int'(m_vld));
            check("std_out",   int'(bus_s.out_fifo),        int'(m_out));
            check("fw_level",  int'(bus_f.level),           q.size());
            check("fw_valid",  int'(bus_f.out_valid),       int'(q.size() > 0));
            if (q.size() > 0) check("fw_out", int'(bus_f.out_fifo), int'(q[0]));
        end
    end

    task automatic cyc(input logic pu, input logic po, input logic fl, input logic [W-1:0] d);
        push  = pu;
        pop   = po;
        flush = fl;
        din   = d;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        en_cmp = 1'b1;

        check("rst_level",  int'(bus_s.level), 0);
        check("rst_empty",  int'(bus_s.is_fifo_empty), 1);
        check("rst_aempty", int'(bus_s.is_almost_empty), 1);
        check("rst_full",   int'(bus_s.is_fifo_full), 0);
        check("rst_valid",  int'(bus_s.out_valid), 0);
        check("rst_ovf",    int'(bus_s.overflow), 0);
        check("rst_udf",    int'(bus_s.underflow), 0);

        // Fill to full, then one rejected push.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, W'(i));
            if (i == 5) check("lit_afull_l5", int'(bus_s.is_almost_full), 0);
            if (i == 6) check("lit_afull_l6", int'(bus_s.is_almost_full), 1);
        end
        check("lit_full8", int'(bus_s.is_fifo_full), 1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0009);
        check("lit_ovf9",   int'(bus_s.overflow), 1);
        check("lit_level8", int'(bus_s.level), 8);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            check("lit_pop_data",  int'(bus_s.out_fifo), i);
            check("lit_pop_valid", int'(bus_s.out_valid), 1);
        end
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("lit_valid_drop",  int'(bus_s.out_valid), 0);
        check("lit_empty_drain", int'(bus_s.is_fifo_empty), 1);

        // Full with simultaneous push and pop.
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("lit_flush_ovf", int'(bus_s.overflow), 0);
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, W'(i));
        cyc(1'b1, 1'b1, 1'b0, 16'h00AA);
        check("lit_fullpp_out",   int'(bus_s.out_fifo), 16'h0001);
        check("lit_fullpp_level", int'(bus_s.level), 8);
        check("lit_fullpp_ovf",   int'(bus_s.overflow), 0);
        for (int i = 2; i <= 9; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            if (i == 9) check("lit_last_aa", int'(bus_s.out_fifo), 16'h00AA);
        end

        // Underflow, then push+pop on empty; FWFT fall-through.
        cyc(1'b0, 1'b1, 1'b0, '0);
        check("lit_udf",       int'(bus_s.underflow), 1);
        check("lit_udf_valid", int'(bus_s.out_valid), 0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0055);
        check("lit_epp_level", int'(bus_s.level), 1);
        check("lit_epp_udf",   int'(bus_s.underflow), 1);
        check("lit_epp_valid", int'(bus_s.out_valid), 0);
        check("lit_fw_out",    int'(bus_f.out_fifo), 16'h0055);
        check("lit_fw_valid",  int'(bus_f.out_valid), 1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        check("lit_epp_pop",   int'(bus_s.out_fifo), 16'h0055);
        check("lit_fw_vdrop",  int'(bus_f.out_valid), 0);

        // Sustained traffic at level 3 across the pointer wrap.
        cyc(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, W'(16'h0100 + i));
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 1'b0, W'(16'h0103 + k));
        check("lit_wrap_last",  int'(bus_s.out_fifo), 16'h0113);
        check("lit_wrap_level", int'(bus_s.level), 3);
        cyc(1'b1, 1'b1, 1'b1, 16'hDEAD);
        check("lit_fl_level", int'(bus_s.level), 0);
        check("lit_fl_empty", int'(bus_s.is_fifo_empty), 1);
        check("lit_fl_ovf",   int'(bus_s.overflow), 0);
        check("lit_fl_udf",   int'(bus_s.underflow), 0);
        check("lit_fl_hold",  int'(bus_s.out_fifo), 16'h0113);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("lit_fl_nostore", int'(bus_s.level), 0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, W'(16'h0200 + i));
        check("lit_pre_rst_level", int'(bus_s.level), 5);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 16'h0BAD);
        check("lit_mrst_level",  int'(bus_s.level), 0);
        check("lit_mrst_empty",  int'(bus_s.is_fifo_empty), 1);
        check("lit_mrst_aempty", int'(bus_s.is_almost_empty), 1);
        check("lit_mrst_full",   int'(bus_s.is_fifo_full), 0);
        check("lit_mrst_afull",  int'(bus_s.is_almost_full), 0);
        check("lit_mrst_out",    int'(bus_s.out_fifo), 0);
        check("lit_mrst_valid",  int'(bus_s.out_valid), 0);
        check("lit_mrst_ovf",    int'(bus_s.overflow), 0);
        check("lit_mrst_udf",    int'(bus_s.underflow), 0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0077);
        cyc(1'b0, 1'b1, 1'b0, '0);
        check("lit_post_rst_pop", int'(bus_s.out_fifo), 16'h0077);
        cyc(1'b0, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
